// File: rtl/seq_feeder_pkg.sv
// Shared types and constants for the seq_feeder stimulus source.
package seq_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } feeder_state_t;

  localparam int FEEDER_LEN_MAX      = 32;
  localparam int DEBOUNCE_50MHZ_10MS = 500000;

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, hold-time debounce, one-cycle press pulse.
module key_debounce
  import seq_feeder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_50MHZ_10MS
) (
  input  logic Clock,
  input  logic Reset,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic          db;
  logic          db_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      db      <= 1'b1;
      db_d    <= 1'b1;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_p0 <= key_n;
      sync_p1 <= sync_p0;
      // A level is accepted only after it has differed from db for the full hold time
      if (sync_p1 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= sync_p1;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      db_d  <= db;
      press <= db_d & ~db;
    end
  end

  assign level = db;

endmodule

// File: rtl/seq_feeder.sv
// Presents a captured LEN-bit pattern MSB first, one bit per debounced key press,
// with a one-cycle w_valid strobe used as the downstream detector's clock enable.
module seq_feeder
  import seq_feeder_pkg::*;
#(
  parameter int LEN             = 16,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_50MHZ_10MS
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic [LEN-1:0] pattern,
  input  logic           load,
  input  logic           wrap,
  input  logic           step_key_n,
  output logic           w,
  output logic           w_valid,
  output logic [4:0]     bit_idx,
  output logic           busy,
  output logic           done
);

  localparam logic [4:0] LAST_IDX = 5'(LEN - 1);

  feeder_state_t  state;
  feeder_state_t  state_nxt;
  logic [LEN-1:0] shreg;
  logic [LEN-1:0] pat_copy;
  logic           step_req;
  logic           key_level;
  logic           step;
  logic           last_bit;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .Clock(Clock),
    .Reset(Reset),
    .key_n(step_key_n),
    .level(key_level),
    .press(step_req)
  );

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // load always wins over a coincident step, so a step only counts without load
  always_comb begin
    state_nxt = state;
    step      = 1'b0;
    last_bit  = (bit_idx == LAST_IDX);
    if (load) begin
      state_nxt = RUN;
    end else if (state == RUN && step_req) begin
      step = 1'b1;
      if (last_bit && !wrap) state_nxt = DONE;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      shreg    <= '0;
      pat_copy <= '0;
      bit_idx  <= '0;
      w        <= 1'b0;
      w_valid  <= 1'b0;
    end else begin
      w_valid <= 1'b0;
      if (load) begin
        shreg    <= pattern;
        pat_copy <= pattern;
        bit_idx  <= '0;
      end else if (step) begin
        w       <= shreg[LEN-1];
        w_valid <= 1'b1;
        // Wrapping reloads from the copy taken at load, never the live pattern input
        if (last_bit && wrap) begin
          shreg   <= pat_copy;
          bit_idx <= '0;
        end else begin
          shreg   <= shreg << 1;
          bit_idx <= bit_idx + 5'd1;
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  logic unused_ok;
  assign unused_ok = key_level;

endmodule

// File: tb/tb_seq_feeder.sv
// Directed bench for seq_feeder with LEN=8, DEBOUNCE_CYCLES=4.
module tb_seq_feeder;

  localparam int LEN = 8;
  localparam int DB  = 4;

  logic           Clock;
  logic           Reset;
  logic [LEN-1:0] pattern;
  logic           load;
  logic           wrap;
  logic           step_key_n;
  logic           w;
  logic           w_valid;
  logic [4:0]     bit_idx;
  logic           busy;
  logic           done;

  int errors;
  int checks;

  seq_feeder #(
    .LEN(LEN),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .pattern(pattern),
    .load(load),
    .wrap(wrap),
    .step_key_n(step_key_n),
    .w(w),
    .w_valid(w_valid),
    .bit_idx(bit_idx),
    .busy(busy),
    .done(done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Clean press: key low for 12 edges then released for 10; reports strobes seen,
  // the w carried by the first strobe and the edge index (0 = first edge after fall).
  task automatic do_press(output int nstb, output logic wv, output int lat);
    nstb = 0;
    wv   = 1'b0;
    lat  = -1;
    @(negedge Clock);
    step_key_n = 1'b0;
    for (int i = 0; i < 22; i++) begin
      @(posedge Clock);
      #1;
      if (w_valid === 1'b1) begin
        if (nstb == 0) begin
          wv  = w;
          lat = i;
        end
        nstb++;
      end
      if (i == 11) begin
        @(negedge Clock);
        step_key_n = 1'b1;
      end
    end
  endtask

  task automatic do_load(input logic [LEN-1:0] p, input logic wr);
    @(negedge Clock);
    pattern = p;
    wrap    = wr;
    load    = 1'b1;
    @(negedge Clock);
    load    = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    int strobes;
    pulse_reset();
    #1;
    checks++;
    if ({w, w_valid, bit_idx, busy, done} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got w=%b wv=%b idx=%0d busy=%b done=%b, want all 0",
               w, w_valid, bit_idx, busy, done);
    end
    strobes = 0;
    @(negedge Clock);
    step_key_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge Clock);
      #1;
      if (w_valid === 1'b1) strobes++;
    end
    @(negedge Clock);
    step_key_n = 1'b1;
    repeat (10) @(posedge Clock);
    checks++;
    if (strobes != 0) begin
      errors++;
      $display("FAIL idle_no_strobe: got %0d strobes, want 0", strobes);
    end
  endtask

  task automatic test_full_run();
    logic [7:0] exp_w;
    int nstb, lat;
    logic wv;
    exp_w = 8'b1111_0000;
    do_load(8'b1111_0000, 1'b0);
    #1;
    checks++;
    if (busy !== 1'b1 || bit_idx !== 5'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL load_state: got busy=%b idx=%0d done=%b, want 1 0 0", busy, bit_idx, done);
    end
    for (int k = 0; k < 8; k++) begin
      do_press(nstb, wv, lat);
      checks++;
      if (nstb != 1 || wv !== exp_w[7-k]) begin
        errors++;
        $display("FAIL run_strobe%0d: got %0d strobes w=%b, want 1 strobe w=%b",
                 k, nstb, wv, exp_w[7-k]);
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL run_done: got done=%b busy=%b, want 1 0", done, busy);
    end
    do_press(nstb, wv, lat);
    checks++;
    if (nstb != 0) begin
      errors++;
      $display("FAIL done_ignores_step: got %0d strobes, want 0", nstb);
    end
  endtask

  task automatic test_debounce();
    int nstb, lat, strobes;
    logic wv;
    do_load(8'b1000_0000, 1'b0);
    strobes = 0;
    @(negedge Clock);
    step_key_n = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    step_key_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge Clock);
      #1;
      if (w_valid === 1'b1) strobes++;
    end
    checks++;
    if (strobes != 0 || bit_idx !== 5'd0) begin
      errors++;
      $display("FAIL glitch: got %0d strobes idx=%0d, want 0 strobes idx=0", strobes, bit_idx);
    end
    do_press(nstb, wv, lat);
    checks++;
    if (lat != DB + 3 || nstb != 1) begin
      errors++;
      $display("FAIL press_latency: got edge %0d (%0d strobes), want edge %0d (1 strobe)",
               lat, nstb, DB + 3);
    end
    checks++;
    if (wv !== 1'b1 || bit_idx !== 5'd1) begin
      errors++;
      $display("FAIL press_data: got w=%b idx=%0d, want w=1 idx=1", wv, bit_idx);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_w;
    int nstb, lat;
    logic wv;
    exp_w = 8'hA5;
    do_load(8'hA5, 1'b1);
    pattern = 8'h00;
    for (int k = 0; k < 10; k++) begin
      do_press(nstb, wv, lat);
      checks++;
      if (nstb != 1 || wv !== exp_w[7 - (k % 8)]) begin
        errors++;
        $display("FAIL wrap_strobe%0d: got %0d strobes w=%b, want 1 strobe w=%b",
                 k, nstb, wv, exp_w[7 - (k % 8)]);
      end
      if (k == 6) begin
        checks++;
        if (bit_idx !== 5'd7) begin
          errors++;
          $display("FAIL wrap_idx7: got %0d, want 7", bit_idx);
        end
      end
      if (k == 7) begin
        checks++;
        if (bit_idx !== 5'd0 || busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL wrap_idx0: got idx=%0d busy=%b done=%b, want 0 1 0", bit_idx, busy, done);
        end
      end
    end
  endtask

  task automatic test_collision();
    int nstb, lat, strobes;
    logic wv;
    do_load(8'hF0, 1'b0);
    do_press(nstb, wv, lat);
    do_press(nstb, wv, lat);
    checks++;
    if (bit_idx !== 5'd2) begin
      errors++;
      $display("FAIL coll_pre_idx: got %0d, want 2", bit_idx);
    end
    strobes = 0;
    @(negedge Clock);
    step_key_n = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(posedge Clock);
      #1;
      if (w_valid === 1'b1) strobes++;
    end
    @(negedge Clock);
    pattern = 8'h0F;
    load    = 1'b1;
    @(posedge Clock);
    #1;
    if (w_valid === 1'b1) strobes++;
    checks++;
    if (bit_idx !== 5'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL coll_idx: got idx=%0d busy=%b, want 0 1", bit_idx, busy);
    end
    @(negedge Clock);
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clock);
      #1;
      if (w_valid === 1'b1) strobes++;
    end
    @(negedge Clock);
    step_key_n = 1'b1;
    repeat (10) @(posedge Clock);
    checks++;
    if (strobes != 0) begin
      errors++;
      $display("FAIL coll_no_strobe: got %0d strobes, want 0", strobes);
    end
    do_press(nstb, wv, lat);
    checks++;
    if (nstb != 1 || wv !== 1'b0 || bit_idx !== 5'd1) begin
      errors++;
      $display("FAIL coll_next: got %0d strobes w=%b idx=%0d, want 1 strobe w=0 idx=1",
               nstb, wv, bit_idx);
    end
  endtask

  task automatic test_midrun_reset();
    int nstb, lat;
    logic wv;
    do_load(8'hF0, 1'b0);
    for (int k = 0; k < 3; k++) do_press(nstb, wv, lat);
    checks++;
    if (w !== 1'b1 || bit_idx !== 5'd3) begin
      errors++;
      $display("FAIL pre_reset: got w=%b idx=%0d, want w=1 idx=3", w, bit_idx);
    end
    pulse_reset();
    #1;
    checks++;
    if ({w, w_valid, bit_idx, busy, done} !== 9'b0) begin
      errors++;
      $display("FAIL midrun_reset: got w=%b wv=%b idx=%0d busy=%b done=%b, want all 0",
               w, w_valid, bit_idx, busy, done);
    end
    do_press(nstb, wv, lat);
    checks++;
    if (nstb != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_press: got %0d strobes busy=%b, want 0 0", nstb, busy);
    end
    do_load(8'h80, 1'b0);
    do_press(nstb, wv, lat);
    checks++;
    if (nstb != 1 || wv !== 1'b1 || bit_idx !== 5'd1) begin
      errors++;
      $display("FAIL reload_press: got %0d strobes w=%b idx=%0d, want 1 strobe w=1 idx=1",
               nstb, wv, bit_idx);
    end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    Reset      = 1'b0;
    pattern    = '0;
    load       = 1'b0;
    wrap       = 1'b0;
    step_key_n = 1'b1;
    test_reset();
    test_full_run();
    test_debounce();
    test_wrap();
    test_collision();
    test_midrun_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
